// File: rtl/pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_pkg : shared types and defaults for the IF/ID skid pipeline stage    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } skid_state_t;

   localparam int PKT_BITS  = 32;
   localparam int PKT_LANES = 1;

   localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

   // Reference layout at the default widths; the stage re-declares it with its own parameters.
   typedef struct packed {
      logic [PKT_BITS-1:0]           pc;
      logic [PKT_BITS-1:0]           pc_next;
      logic [PKT_LANES*PKT_BITS-1:0] instr;
   } if_id_pkt_t;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sat_counter : saturating up-counter with synchronous clear               |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic             clear_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst_) begin
      if (rst_) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipe_if_id_skid.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_if_id_skid : IF/ID pipeline register with 2-entry skid and flush.   |
// | Optional perf counters when PIPE_IF_ID_PERF_EN is defined.               |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
module pipe_if_id_skid
   import pipe_pkg::*;
#(
   parameter int              BITS     = 32,
   parameter int              LANES    = 1,
   parameter int              PC_INC   = 4,
   parameter logic [BITS-1:0] NOP_WORD = BITS'(NOP_WORD_DEFAULT)
) (
   input  logic                  clk,
   input  logic                  rst_,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [BITS-1:0]       pc_in,
   input  logic [LANES*BITS-1:0] instr_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [BITS-1:0]       pc_out,
   output logic [LANES*BITS-1:0] instr_out,
   output logic [BITS-1:0]       pc_next_out
`ifdef PIPE_IF_ID_PERF_EN
   ,
   output logic [31:0]           stall_cnt,
   output logic [31:0]           flush_cnt
`endif
);

   localparam int              IW     = LANES * BITS;
   localparam logic [BITS-1:0] STRIDE = BITS'(LANES * PC_INC);

   typedef struct packed {
      logic [BITS-1:0] pc;
      logic [BITS-1:0] pc_next;
      logic [IW-1:0]   instr;
   } pkt_t;

   skid_state_t state_q;
   skid_state_t state_d;
   pkt_t        head_q;
   pkt_t        head_d;
   pkt_t        skid_q;
   pkt_t        skid_d;
   pkt_t        in_pkt;
   logic        acc;
   logic        pop;

   // pc_next is computed once at capture so the output path is a plain register.
   assign in_pkt.pc      = pc_in;
   assign in_pkt.pc_next = pc_in + STRIDE;
   assign in_pkt.instr   = instr_in;

   // Handshake flags come only from the state register: no in->out comb path.
   assign in_ready  = (state_q != ST_TWO);
   assign out_valid = (state_q != ST_EMPTY);
   assign acc       = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (acc) begin
                  state_d = ST_ONE;
                  head_d  = in_pkt;
               end
            end
            ST_ONE: begin
               if (acc && pop) begin
                  head_d = in_pkt;
               end else if (acc) begin
                  state_d = ST_TWO;
                  skid_d  = in_pkt;
               end else if (pop) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (pop) begin
                  state_d = ST_ONE;
                  head_d  = skid_q;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst_) begin
      if (rst_) begin
         state_q <= ST_EMPTY;
         head_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         skid_q  <= skid_d;
      end
   end

   assign pc_out      = head_q.pc;
   assign pc_next_out = head_q.pc_next;

   always_comb begin
      instr_out = {LANES{NOP_WORD}};
      if (out_valid) begin
         instr_out = head_q.instr;
      end
   end

`ifdef PIPE_IF_ID_PERF_EN
   logic stall_inc;
   logic flush_inc;

   assign stall_inc = out_valid & ~out_ready;
   assign flush_inc = flush & (state_q != ST_EMPTY);

   sat_counter #(
      .WIDTH (32)
   ) u_stall_cnt (
      .clk     (clk),
      .rst_    (rst_),
      .clear_i (1'b0),
      .inc_i   (stall_inc),
      .count_o (stall_cnt)
   );

   sat_counter #(
      .WIDTH (32)
   ) u_flush_cnt (
      .clk     (clk),
      .rst_    (rst_),
      .clear_i (1'b0),
      .inc_i   (flush_inc),
      .count_o (flush_cnt)
   );
`endif

endmodule : pipe_if_id_skid
`default_nettype wire

// File: tb/tb_pipe_if_id_skid.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipe_if_id_skid : scoreboard bench for the IF/ID skid stage           |
// | Revision           : 1.0                                                 |
// +--------------------------------------------------------------------------+
module tb_pipe_if_id_skid;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pcn;
      logic [31:0] instr;
   } exp_t;

   logic        clk;
   logic        rst_;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] pc_in;
   logic [31:0] instr_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] pc_out;
   logic [31:0] instr_out;
   logic [31:0] pc_next_out;

   logic        flush2;
   logic        in_valid2;
   logic        in_ready2;
   logic [31:0] pc_in2;
   logic [63:0] instr_in2;
   logic        out_valid2;
   logic        out_ready2;
   logic [31:0] pc_out2;
   logic [63:0] instr_out2;
   logic [31:0] pc_next_out2;

`ifdef PIPE_IF_ID_PERF_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;
   logic [31:0] stall_cnt2;
   logic [31:0] flush_cnt2;
`endif

   int   checks = 0;
   int   errors = 0;
   exp_t q[$];

   pipe_if_id_skid #(
      .BITS   (32),
      .LANES  (1),
      .PC_INC (4)
   ) dut (
      .clk         (clk),
      .rst_        (rst_),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .pc_in       (pc_in),
      .instr_in    (instr_in),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .pc_out      (pc_out),
      .instr_out   (instr_out),
      .pc_next_out (pc_next_out)
`ifdef PIPE_IF_ID_PERF_EN
      ,
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt)
`endif
   );

   pipe_if_id_skid #(
      .BITS   (32),
      .LANES  (2),
      .PC_INC (4)
   ) dut2 (
      .clk         (clk),
      .rst_        (rst_),
      .flush       (flush2),
      .in_valid    (in_valid2),
      .in_ready    (in_ready2),
      .pc_in       (pc_in2),
      .instr_in    (instr_in2),
      .out_valid   (out_valid2),
      .out_ready   (out_ready2),
      .pc_out      (pc_out2),
      .instr_out   (instr_out2),
      .pc_next_out (pc_next_out2)
`ifdef PIPE_IF_ID_PERF_EN
      ,
      .stall_cnt   (stall_cnt2),
      .flush_cnt   (flush_cnt2)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "watchdog");
   end

   // Head of the stage must always match the oldest expected packet; pop on handshake.
   always @(negedge clk) begin
      if (!rst_ && out_valid) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out actual pc=%h required none", pc_out);
         end else begin
            if (pc_out !== q[0].pc || pc_next_out !== q[0].pcn || instr_out !== q[0].instr) begin
               errors++;
               $display("FAIL head_pkt actual pc=%h pcn=%h ins=%h required pc=%h pcn=%h ins=%h",
                        pc_out, pc_next_out, instr_out, q[0].pc, q[0].pcn, q[0].instr);
            end
            if (out_ready) begin
               void'(q.pop_front());
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   // One clock of stimulus; expected packets are queued on accept, cleared on flush.
   task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] pcn,
                        input logic [31:0] ins, input logic ordy, input logic fl);
      exp_t e;
      in_valid  = v;
      pc_in     = pc;
      instr_in  = ins;
      out_ready = ordy;
      flush     = fl;
      @(negedge clk);
      #1;
      if (fl) begin
         q.delete();
      end else if (v && in_ready) begin
         e.pc    = pc;
         e.pcn   = pcn;
         e.instr = ins;
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      flush    = 1'b0;
   endtask

   initial begin
      rst_       = 1'b1;
      flush      = 1'b0;
      in_valid   = 1'b0;
      pc_in      = '0;
      instr_in   = '0;
      out_ready  = 1'b0;
      flush2     = 1'b0;
      in_valid2  = 1'b0;
      pc_in2     = '0;
      instr_in2  = '0;
      out_ready2 = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_pc_out", {32'd0, pc_out}, 64'd0);
      chk("rst_pc_next", {32'd0, pc_next_out}, 64'd0);
      chk("rst_instr_nop", {32'd0, instr_out}, 64'd0);
      rst_ = 1'b0;

      // Streaming at full rate
      cycle(1'b1, 32'h100, 32'h104, 32'hA000_0100, 1'b1, 1'b0);
      chk("stream_rdy0", {63'd0, in_ready}, 64'd1);
      cycle(1'b1, 32'h104, 32'h108, 32'hA000_0104, 1'b1, 1'b0);
      chk("stream_rdy1", {63'd0, in_ready}, 64'd1);
      cycle(1'b1, 32'h108, 32'h10C, 32'hA000_0108, 1'b1, 1'b0);
      chk("stream_rdy2", {63'd0, in_ready}, 64'd1);
      chk("stream_pc_lat", {32'd0, pc_out}, 64'h108);
      cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("stream_drained", {63'd0, out_valid}, 64'd0);

      // Backpressure fills the skid; a third offer while full is ignored
      cycle(1'b1, 32'h200, 32'h204, 32'hB000_0200, 1'b0, 1'b0);
      chk("bp_rdy_one", {63'd0, in_ready}, 64'd1);
      cycle(1'b1, 32'h204, 32'h208, 32'hB000_0204, 1'b0, 1'b0);
      chk("bp_rdy_full", {63'd0, in_ready}, 64'd0);
      cycle(1'b1, 32'h208, 32'h20C, 32'hB000_0208, 1'b0, 1'b0);
      chk("bp_hold_pc", {32'd0, pc_out}, 64'h200);
      repeat (3) cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("bp_drained", {63'd0, out_valid}, 64'd0);

      // Flush while full with a colliding input
      cycle(1'b1, 32'h2F0, 32'h2F4, 32'hC000_02F0, 1'b0, 1'b0);
      cycle(1'b1, 32'h2F4, 32'h2F8, 32'hC000_02F4, 1'b0, 1'b0);
      cycle(1'b1, 32'h300, 32'h304, 32'hC000_0300, 1'b0, 1'b1);
      chk("flush2_valid", {63'd0, out_valid}, 64'd0);
      chk("flush2_rdy", {63'd0, in_ready}, 64'd1);
      chk("flush2_nop", {32'd0, instr_out}, 64'd0);
      cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

      // Flush in ONE with an input that would otherwise be accepted
      cycle(1'b1, 32'h310, 32'h314, 32'hC000_0310, 1'b0, 1'b0);
      cycle(1'b1, 32'h300, 32'h304, 32'hC000_0300, 1'b0, 1'b1);
      chk("flush1_valid", {63'd0, out_valid}, 64'd0);
      cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

      // Flush with a same-cycle pop: that packet is still delivered
      cycle(1'b1, 32'h320, 32'h324, 32'hC000_0320, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
      chk("flushpop_valid", {63'd0, out_valid}, 64'd0);

      // Asynchronous reset while full
      cycle(1'b1, 32'h500, 32'h504, 32'hD000_0500, 1'b0, 1'b0);
      cycle(1'b1, 32'h504, 32'h508, 32'hD000_0504, 1'b0, 1'b0);
      chk("mid_full", {63'd0, in_ready}, 64'd0);
      rst_ = 1'b1;
      #1;
      chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
      chk("mid_rst_rdy", {63'd0, in_ready}, 64'd1);
      chk("mid_rst_pc", {32'd0, pc_out}, 64'd0);
      chk("mid_rst_pcn", {32'd0, pc_next_out}, 64'd0);
      chk("mid_rst_nop", {32'd0, instr_out}, 64'd0);
      q.delete();
      @(posedge clk);
      #1;
      rst_ = 1'b0;
      chk("post_rst_rdy", {63'd0, in_ready}, 64'd1);
      chk("post_rst_valid", {63'd0, out_valid}, 64'd0);

      // Stall/flush activity for the counters: 5 stalls, 1 empty flush, 2 real flushes
      cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
      cycle(1'b1, 32'h400, 32'h404, 32'hE000_0400, 1'b0, 1'b0);
      repeat (5) cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
      cycle(1'b1, 32'h410, 32'h414, 32'hE000_0410, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
`ifdef PIPE_IF_ID_PERF_EN
      chk("stall_cnt", {32'd0, stall_cnt}, 64'd5);
      chk("flush_cnt", {32'd0, flush_cnt}, 64'd2);
`endif

      cycle(1'b1, 32'h600, 32'h604, 32'hF000_0600, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("queue_empty", {32'd0, 32'(q.size())}, 64'd0);

      // Two lanes with PC wrap
      in_valid2  = 1'b1;
      pc_in2     = 32'hFFFF_FFFC;
      instr_in2  = 64'hBBBB_0002_AAAA_0001;
      out_ready2 = 1'b1;
      @(posedge clk);
      #1;
      in_valid2 = 1'b0;
      chk("l2_valid", {63'd0, out_valid2}, 64'd1);
      chk("l2_pc", {32'd0, pc_out2}, 64'hFFFF_FFFC);
      chk("l2_pc_wrap", {32'd0, pc_next_out2}, 64'h4);
      chk("l2_lane1", {32'd0, instr_out2[63:32]}, 64'hBBBB_0002);
      chk("l2_lane0", {32'd0, instr_out2[31:0]}, 64'hAAAA_0001);
      @(posedge clk);
      #1;
      chk("l2_empty", {63'd0, out_valid2}, 64'd0);
      chk("l2_nop", instr_out2, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_pipe_if_id_skid
`default_nettype wire

// File: doc/pipe_if_id_skid.md
Name: pipe_if_id_skid

Overview:
Parametrised IF/ID pipeline register, the successor to the fixed 32-bit IF/ID latch. It carries PC, fetched instruction word(s) and PC+increment from fetch into decode. A valid/ready handshake, a 2-entry skid buffer and flush let fetch run at full rate while decode stalls, with no combinational ready path back to fetch. Sits between the fetch unit (instruction memory plus PC register) and the decode/regfile stage.

Parameters:
- BITS, 32, word and PC width.
- LANES, 1, instructions fetched per cycle; the instruction bus is LANES*BITS wide.
- PC_INC, 4, byte increment per lane; pc_next_out = pc + LANES*PC_INC.
- NOP_WORD, 32'h0000_0000, value driven on instruction lanes when out_valid=0.

Ports:
- clk  in  1  clock, rising edge.
- rst_  in  1  asynchronous, active-high reset. The name follows the codebase; the polarity is high.
- flush  in  1  kill all held entries (branch taken / redirect).
- in_valid  in  1  fetch presents a packet.
- in_ready  out  1  stage can accept; decoded from state register only.
- pc_in  in  BITS  PC of lane 0.
- instr_in  in  LANES*BITS  fetched instruction word(s); lane 0 in the LSBs.
- out_valid  out  1  decode packet valid.
- out_ready  in  1  decode accepts.
- pc_out  out  BITS  PC of the head packet.
- instr_out  out  LANES*BITS  head instructions, or NOP_WORD per lane when out_valid=0.
- pc_next_out  out  BITS  pc_out + LANES*PC_INC, modulo 2^BITS.

Behaviour:
- Storage: a main register (head) and a skid register, each holding {pc, instr}. pc_next is computed at capture and stored.
- States:
  - EMPTY: nothing held.
  - ONE: head valid.
  - TWO: head and skid valid.
- Derived signals:
  - in_ready = (state != TWO).
  - out_valid = (state != EMPTY).
  - Transfer in: acc = in_valid & in_ready.
  - Transfer out: pop = out_valid & out_ready.
- Transitions when flush=0:
  - EMPTY: acc -> ONE, head <= input.
  - ONE, acc & pop: stay ONE, head <= input.
  - ONE, acc & !pop: -> TWO, skid <= input.
  - ONE, !acc & pop: -> EMPTY.
  - TWO, pop: -> ONE, head <= skid. No accept is possible in TWO.
  - Otherwise: hold.
- flush=1: next state is EMPTY regardless of acc or pop. An input presented in the same cycle is dropped. A pop in the same cycle still counts as consumed by decode, because it was visible. in_ready=1 on the following cycle.
- Latency: an accept into EMPTY gives out_valid on the next edge (1 cycle). Ordering is strict FIFO.
- Throughput: 1 packet/cycle sustained while out_ready=1.
- Reset, asynchronous, effective immediately:
  - state = EMPTY, in_ready = 1, out_valid = 0.
  - head and skid data = 0, so pc_out = 0, pc_next_out = 0, instr_out = NOP_WORD.
- Reset mid-operation: all held packets are lost and no partial update occurs. The first edge after deassertion behaves as EMPTY.
- Stability rule: while out_valid=1 and out_ready=0, the head outputs must not change.
- PC wrap: pc_next_out wraps modulo 2^BITS. No overflow flag.
- Illegal combination (in_ready=0 with in_valid=1): the input is simply ignored; fetch must hold it.

Optional Feature:
- Macro: PIPE_IF_ID_PERF_EN.
- When defined, two extra output ports are added:
  - stall_cnt [31:0]: increments each cycle with out_valid & !out_ready.
  - flush_cnt [31:0]: increments each cycle with flush=1 and state != EMPTY.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- When not defined, the ports and counters are absent and the interface and behaviour are otherwise identical.

Decomposition:
- Shared package pipe_pkg:
  - typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} skid_state_t.
  - Packed struct if_id_pkt_t {pc, pc_next, instr} parameterised via BITS/LANES localparams.
  - NOP_WORD default constant.
- One sub-module: sat_counter (width 32, inc, clear), instantiated twice under PIPE_IF_ID_PERF_EN.

Test Plan:
- Reset: assert rst_ mid-run with state TWO -> outputs go to 0 / NOP immediately. After release: in_ready=1, out_valid=0.
- Streaming: out_ready=1, feed pc 0x100, 0x104, 0x108 on back-to-back cycles -> outputs appear one cycle later in order. pc_next_out = 0x104, 0x108, 0x10C. in_ready stays 1.
- Backpressure: out_ready=0, send pc 0x200 then 0x204 -> in_ready drops to 0 after the second accept, and pc_out holds 0x200. Raise out_ready -> 0x200, then 0x204, with no loss or duplication.
- Flush collision: state TWO, flush=1 with in_valid=1 (pc 0x300) -> next cycle out_valid=0 and in_ready=1; 0x300 is never output.
- Wrap and lanes: LANES=2, pc_in=0xFFFF_FFFC -> pc_next_out=0x0000_0004. Lane 1 of instr_out equals instr_in[63:32].
- PIPE_IF_ID_PERF_EN: 5 stall cycles plus 2 flushes with a non-empty stage -> stall_cnt=5, flush_cnt=2. A flush when EMPTY does not increment flush_cnt.
